// File: rtl/mdio_master_c45.sv
// -----------------------------------------------------------------------------
// mdio_master_c45
// MDIO management master generating Clause-22 or Clause-45 frames.
//
// A command (frame type, OP, PHY/PRTAD, REG/DEVAD, write data or C45 address)
// is accepted on cmd_valid & cmd_ready. The frame is serialised as
// PRE (PREAMBLE_LEN ones), ST, OP, PHY, REG, TA, DATA, followed by one idle
// bit period (GAP) before the next command can be accepted. rsp_valid pulses
// on the first GAP cycle with the read data and a no-response error flag.
// An illegal Clause-22 op is answered with an error one cycle after
// acceptance and no frame is sent.
//
// Ports:
//   sys_clk, sys_rst_n            clock, asynchronous active-low reset
//   cmd_valid / cmd_ready         command handshake (ready only in IDLE)
//   cmd_c45, cmd_op, cmd_phy,
//   cmd_reg, cmd_wdata            command fields, latched on acceptance
//   rsp_valid, rsp_rdata, rsp_err completion pulse, read data, error flag
//   eth_mdc                       management clock (low when idle)
//   eth_mdio                      management data, open line with pull-up
// -----------------------------------------------------------------------------
module mdio_master_c45 #(
    parameter int unsigned CLK_DIV      = 10,
    parameter int unsigned PREAMBLE_LEN = 32
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_c45,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_phy,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        eth_mdc,
    inout  wire         eth_mdio
);

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [5:0] PRE_LAST  = 6'(PREAMBLE_LEN - 1);
    localparam logic [5:0] HDR_LAST  = 6'd13;
    localparam logic [5:0] TA_LAST   = 6'd1;
    localparam logic [5:0] DATA_LAST = 6'd15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_HDR  = 3'd2,
        ST_TA   = 3'd3,
        ST_DATA = 3'd4,
        ST_GAP  = 3'd5,
        ST_ERR  = 3'd6
    } state_e;

    // Read-type ops release the line during TA and DATA.
    function automatic logic is_read_op(input logic c45, input logic [1:0] op);
        if (c45) begin
            return op[1];
        end else begin
            return (op == 2'b10);
        end
    endfunction

    // Clause-22 only defines write (01) and read (10).
    function automatic logic is_illegal_op(input logic c45, input logic [1:0] op);
        return (!c45) && ((op == 2'b00) || (op == 2'b11));
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic        ph_q, ph_d;          // 0 = low half of bit period, 1 = high half
    logic [5:0]  bit_q, bit_d;        // bits remaining in current state minus one
    logic [31:0] frame_q, frame_d;    // ST..DATA, current bit at [31]
    logic        rd_q, rd_d;
    logic [15:0] rx_q, rx_d;
    logic        ta_err_q, ta_err_d;
    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        mdc_q, mdc_d;
    logic        oe_q, oe_d;
    logic        dout_q, dout_d;

    logic        tick_s;
    logic        mdio_in_s;
    logic        cmd_rd_s;

    assign mdio_in_s = eth_mdio;
    assign eth_mdio  = oe_q ? dout_q : 1'bz;

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign eth_mdc   = mdc_q;

    assign tick_s   = (div_q == DIV_LAST);
    assign cmd_rd_s = is_read_op(cmd_c45, cmd_op);

    // Next-state, counter and output computation.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        ph_d        = ph_q;
        bit_d       = bit_q;
        frame_d     = frame_q;
        rd_d        = rd_q;
        rx_d        = rx_q;
        ta_err_d    = ta_err_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (is_illegal_op(cmd_c45, cmd_op)) begin
                        state_d     = ST_ERR;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d  = ST_PRE;
                        bit_d    = PRE_LAST;
                        div_d    = 8'd0;
                        ph_d     = 1'b0;
                        rd_d     = cmd_rd_s;
                        ta_err_d = 1'b0;
                        // Read frames keep TA/DATA as ones; those bits are released anyway.
                        frame_d  = {(cmd_c45 ? 2'b00 : 2'b01), cmd_op, cmd_phy, cmd_reg,
                                    (cmd_rd_s ? 2'b11 : 2'b10),
                                    (cmd_rd_s ? 16'hFFFF : cmd_wdata)};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ERR: begin
                state_d = ST_IDLE;
            end

            ST_PRE, ST_HDR, ST_TA, ST_DATA, ST_GAP: begin
                if (tick_s) begin
                    div_d = 8'd0;
                    ph_d  = ~ph_q;
                    if (!ph_q) begin
                        // This edge raises MDC: sample the line for read ops.
                        if ((state_q == ST_TA) && (bit_q == 6'd0)) begin
                            ta_err_d = mdio_in_s;
                        end else if (state_q == ST_DATA) begin
                            rx_d = {rx_q[14:0], mdio_in_s};
                        end else begin
                            rx_d = rx_q;
                        end
                    end else begin
                        // End of bit period: advance to the next bit.
                        if ((state_q == ST_HDR) || (state_q == ST_TA) || (state_q == ST_DATA)) begin
                            frame_d = {frame_q[30:0], 1'b0};
                        end else begin
                            frame_d = frame_q;
                        end
                        if (bit_q != 6'd0) begin
                            bit_d = bit_q - 6'd1;
                        end else begin
                            case (state_q)
                                ST_PRE: begin
                                    state_d = ST_HDR;
                                    bit_d   = HDR_LAST;
                                end
                                ST_HDR: begin
                                    state_d = ST_TA;
                                    bit_d   = TA_LAST;
                                end
                                ST_TA: begin
                                    state_d = ST_DATA;
                                    bit_d   = DATA_LAST;
                                end
                                ST_DATA: begin
                                    state_d     = ST_GAP;
                                    bit_d       = 6'd0;
                                    rsp_valid_d = 1'b1;
                                    rsp_err_d   = rd_q & ta_err_q;
                                    rsp_rdata_d = rd_q ? rx_q : rsp_rdata_q;
                                end
                                default: begin
                                    state_d = ST_IDLE;
                                    bit_d   = 6'd0;
                                end
                            endcase
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        mdc_d   = ph_d && ((state_d == ST_PRE) || (state_d == ST_HDR) ||
                           (state_d == ST_TA)  || (state_d == ST_DATA));

        case (state_d)
            ST_PRE: begin
                oe_d   = 1'b1;
                dout_d = 1'b1;
            end
            ST_HDR: begin
                oe_d   = 1'b1;
                dout_d = frame_d[31];
            end
            ST_TA, ST_DATA: begin
                oe_d   = ~rd_d;
                dout_d = frame_d[31];
            end
            default: begin
                oe_d   = 1'b0;
                dout_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            div_q       <= 8'd0;
            ph_q        <= 1'b0;
            bit_q       <= 6'd0;
            frame_q     <= 32'd0;
            rd_q        <= 1'b0;
            rx_q        <= 16'd0;
            ta_err_q    <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 16'h0000;
            mdc_q       <= 1'b0;
            oe_q        <= 1'b0;
            dout_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            ph_q        <= ph_d;
            bit_q       <= bit_d;
            frame_q     <= frame_d;
            rd_q        <= rd_d;
            rx_q        <= rx_d;
            ta_err_q    <= ta_err_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mdc_q       <= mdc_d;
            oe_q        <= oe_d;
            dout_q      <= dout_d;
        end
    end

endmodule

// File: tb/tb_mdio_master_c45.sv
// -----------------------------------------------------------------------------
// tb_mdio_master_c45
// Directed bench for mdio_master_c45. A frame-level model predicts MDC, the
// MDIO line value, handshake and response on every cycle of every command;
// a PHY slave answers read frames for PHY address 7. A second instance with
// PREAMBLE_LEN=1, CLK_DIV=2 checks the short-preamble build.
// -----------------------------------------------------------------------------
module tb_mdio_master_c45;

    localparam int D  = 10;
    localparam int P  = 32;
    localparam int D2 = 2;
    localparam int P2 = 1;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        cmd_valid, cmd_c45;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_phy, cmd_reg;
    logic [15:0] cmd_wdata;
    logic        cmd_ready, rsp_valid, rsp_err, eth_mdc;
    logic [15:0] rsp_rdata;
    wire         eth_mdio;

    logic        cmd_valid2, cmd_c45_2;
    logic [1:0]  cmd_op2;
    logic [4:0]  cmd_phy2, cmd_reg2;
    logic [15:0] cmd_wdata2;
    logic        cmd_ready2, rsp_valid2, rsp_err2, eth_mdc2;
    logic [15:0] rsp_rdata2;
    wire         eth_mdio2;

    logic        slv_oe, slv_d;

    always #5 sys_clk = ~sys_clk;

    pullup (eth_mdio);
    pullup (eth_mdio2);
    assign eth_mdio = slv_oe ? slv_d : 1'bz;

    mdio_master_c45 #(.CLK_DIV(D), .PREAMBLE_LEN(P)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_c45(cmd_c45),
        .cmd_op(cmd_op), .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .eth_mdc(eth_mdc), .eth_mdio(eth_mdio)
    );

    mdio_master_c45 #(.CLK_DIV(D2), .PREAMBLE_LEN(P2)) dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_c45(cmd_c45_2),
        .cmd_op(cmd_op2), .cmd_phy(cmd_phy2), .cmd_reg(cmd_reg2), .cmd_wdata(cmd_wdata2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
        .eth_mdc(eth_mdc2), .eth_mdio(eth_mdio2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model of the command in flight
    bit          active = 1'b0;
    bit          hold = 1'b1;
    int          acc_cyc = 0;
    int          nb = 0, lat = 0, done_k = 0;
    bit          exp_bits [64];
    bit          exp_rd = 1'b0, exp_err = 1'b0, slv_present = 1'b0;
    logic [15:0] exp_rdata = 16'h0000;
    logic [15:0] model_rdata = 16'h0000;
    logic [15:0] mmd_addr = 16'h0000;

    // Observations gathered by the compare process
    int          rsp_k = -1, rsp_cnt = 0, mdc_rises = 0;
    bit          last_err = 1'b0;
    logic [63:0] cap = 64'd0;

    int          k_now, slv_b;
    int          cb, cph;
    bit          cin;
    logic        c_mdc, c_line;

    assign k_now = cyc - acc_cyc + 1;
    assign slv_b = (k_now - 1) / (2 * D);

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(posedge eth_mdc) begin
        cap       <= {cap[62:0], eth_mdio};
        mdc_rises <= mdc_rises + 1;
    end

    // PHY slave: drives TA bit 2 and DATA of read frames when present.
    always_comb begin
        slv_oe = 1'b0;
        slv_d  = 1'b1;
        if (active && exp_rd && slv_present && (k_now >= 1) && (k_now <= nb * 2 * D) &&
            (slv_b >= P + 15)) begin
            slv_oe = 1'b1;
            slv_d  = exp_bits[slv_b];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] slave_value(input bit c45, input logic [4:0] dev,
                                                input logic [15:0] addr);
        if (!c45) begin
            return (dev == 5'h01) ? 16'h7826 : 16'h1234;
        end else begin
            return ((dev == 5'h01) && (addr == 16'h0010)) ? 16'hBEEF : 16'h0BAD;
        end
    endfunction

    // Compare process: DUT outputs versus the frame model, every cycle.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            model_rdata = 16'h0000;
        end else if (!hold) begin
            if (active) begin
                cin    = (k_now <= nb * 2 * D);
                cb     = cin ? (k_now - 1) / (2 * D) : 0;
                cph    = (k_now - 1) % (2 * D);
                c_mdc  = cin && (cph >= D);
                c_line = cin ? exp_bits[cb] : 1'b1;
                chk("mdc", 32'(eth_mdc), 32'(c_mdc));
                chk("mdio_line", 32'(eth_mdio), 32'(c_line));
                chk("rsp_valid", 32'(rsp_valid), 32'(k_now == lat));
                chk("cmd_ready", 32'(cmd_ready), 32'(k_now >= done_k));
                if (k_now == lat) begin
                    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
                    model_rdata = exp_rdata;
                end else begin
                    chk("rdata_hold", 32'(rsp_rdata), 32'(model_rdata));
                end
            end else begin
                chk("idle_mdc", 32'(eth_mdc), 32'd0);
                chk("idle_mdio", 32'(eth_mdio), 32'd1);
                chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("idle_ready", 32'(cmd_ready), 32'd1);
                chk("idle_rdata", 32'(rsp_rdata), 32'(model_rdata));
            end
            if (rsp_valid) begin
                rsp_k    = active ? k_now : -1;
                rsp_cnt  = rsp_cnt + 1;
                last_err = rsp_err;
            end
        end
    end

    // Issue one command and follow it to IDLE, or abort it with reset at abort_k.
    task automatic do_cmd(input bit c45, input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] rg, input logic [15:0] wd, input int abort_k);
        bit          rd, ill;
        logic [15:0] resp, dat;
        logic [1:0]  ta;
        logic [31:0] word;
        ill  = !c45 && ((op == 2'b00) || (op == 2'b11));
        rd   = c45 ? op[1] : (op == 2'b10);
        slv_present = (phy == 5'h07);
        resp = slv_present ? slave_value(c45, rg, mmd_addr) : 16'hFFFF;
        ta   = rd ? {1'b1, ~slv_present} : 2'b10;
        dat  = rd ? resp : wd;
        word = {(c45 ? 2'b00 : 2'b01), op, phy, rg, ta, dat};
        for (int i = 0; i < 64; i++) exp_bits[i] = 1'b1;
        for (int i = 0; i < 32; i++) exp_bits[P + i] = word[31 - i];
        exp_rd    = rd;
        nb        = ill ? 0 : P + 32;
        lat       = ill ? 1 : 1 + nb * 2 * D;
        done_k    = ill ? 2 : lat + 2 * D;
        exp_err   = ill || (rd && !slv_present);
        exp_rdata = rd && !ill ? resp : model_rdata;

        cmd_valid = 1'b1; cmd_c45 = c45; cmd_op = op;
        cmd_phy = phy; cmd_reg = rg; cmd_wdata = wd;
        @(posedge sys_clk); #1;
        acc_cyc = cyc;
        active  = 1'b1;
        cmd_valid = 1'b0; cmd_c45 = ~c45; cmd_op = ~op;
        cmd_phy = ~phy; cmd_reg = ~rg; cmd_wdata = ~wd;

        if (abort_k > 0) begin
            repeat (abort_k - 1) @(posedge sys_clk);
            #1;
            hold      = 1'b1;
            active    = 1'b0;
            sys_rst_n = 1'b0;
            #1;
            chk("abort_mdc", 32'(eth_mdc), 32'd0);
            chk("abort_mdio", 32'(eth_mdio), 32'd1);
            chk("abort_ready", 32'(cmd_ready), 32'd1);
            chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
            repeat (3) @(posedge sys_clk);
            #1;
            sys_rst_n = 1'b1;
            hold      = 1'b0;
        end else begin
            repeat (done_k) @(posedge sys_clk);
            #1;
            active = 1'b0;
            if (c45 && slv_present && (op == 2'b00)) mmd_addr = wd;
            if (c45 && slv_present && (op == 2'b10)) mmd_addr = mmd_addr + 16'd1;
        end
    endtask

    initial begin
        int n;
        int cnt0;
        sys_rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_c45 = 1'b0; cmd_op = 2'b00;
        cmd_phy = 5'h00; cmd_reg = 5'h00; cmd_wdata = 16'h0000;
        cmd_valid2 = 1'b0; cmd_c45_2 = 1'b0; cmd_op2 = 2'b00;
        cmd_phy2 = 5'h00; cmd_reg2 = 5'h00; cmd_wdata2 = 16'h0000;

        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'h0000);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_mdc", 32'(eth_mdc), 32'd0);
        chk("rst_mdio", 32'(eth_mdio), 32'd1);
        sys_rst_n = 1'b1;
        hold = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;

        // C22 write phy 7 reg 0 data 8000
        do_cmd(1'b0, 2'b01, 5'h07, 5'h00, 16'h8000, 0);
        chk("wr_frame_pre", cap[63:32], 32'hFFFFFFFF);
        chk("wr_frame_body", cap[31:0], 32'h53828000);
        chk("wr_latency", 32'(rsp_k), 32'd1281);
        chk("wr_err", 32'(last_err), 32'd0);

        // C22 read phy 7 reg 1
        do_cmd(1'b0, 2'b10, 5'h07, 5'h01, 16'h0000, 0);
        chk("rd_data", 32'(rsp_rdata), 32'h7826);
        chk("rd_err", 32'(last_err), 32'd0);

        // C22 read to absent phy
        do_cmd(1'b0, 2'b10, 5'h1F, 5'h01, 16'h0000, 0);
        chk("absent_data", 32'(rsp_rdata), 32'hFFFF);
        chk("absent_err", 32'(last_err), 32'd1);

        // C45 address then read
        do_cmd(1'b1, 2'b00, 5'h07, 5'h01, 16'h0010, 0);
        chk("c45_addr_st", 32'(cap[31:30]), 32'd0);
        chk("c45_addr_hold", 32'(rsp_rdata), 32'hFFFF);
        do_cmd(1'b1, 2'b11, 5'h07, 5'h01, 16'h0000, 0);
        chk("c45_rd_st", 32'(cap[31:30]), 32'd0);
        chk("c45_rd_data", 32'(rsp_rdata), 32'hBEEF);

        // Illegal C22 op 11
        n = mdc_rises;
        do_cmd(1'b0, 2'b11, 5'h07, 5'h00, 16'h0000, 0);
        chk("ill_mdc_rises", 32'(mdc_rises - n), 32'd0);
        chk("ill_latency", 32'(rsp_k), 32'd1);
        chk("ill_err", 32'(last_err), 32'd1);

        // Reset during DATA of a write
        cnt0 = rsp_cnt;
        do_cmd(1'b0, 2'b01, 5'h07, 5'h00, 16'h8000, (P + 20) * 2 * D + 3);
        repeat (1400) @(posedge sys_clk);
        #1;
        chk("abort_no_rsp", 32'(rsp_cnt - cnt0), 32'd0);
        chk("abort_rdata", 32'(rsp_rdata), 32'h0000);
        do_cmd(1'b0, 2'b01, 5'h07, 5'h00, 16'h1140, 0);
        chk("post_rst_latency", 32'(rsp_k), 32'd1281);

        // PREAMBLE_LEN=1 build: read of absent phy in 33 bit periods
        cmd_valid2 = 1'b1; cmd_op2 = 2'b10; cmd_phy2 = 5'h1F; cmd_reg2 = 5'h01;
        @(posedge sys_clk);
        #1;
        cmd_valid2 = 1'b0;
        n = 0;
        while (!rsp_valid2 && (n < 1000)) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        chk("p1_latency", 32'(n + 1), 32'd133);
        chk("p1_err", 32'(rsp_err2), 32'd1);
        chk("p1_rdata", 32'(rsp_rdata2), 32'hFFFF);

        repeat (5) @(posedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
